// File: rtl/demux_1x3.sv
// -----------------------------------------------------------------------------
// demux_1x3 -- registered 1-to-3 stream demultiplexer
//
// Purpose:
//   Steers each beat of a single valid/ready input stream into one of three
//   independent one-entry output registers, chosen by a 2-bit select carried
//   with the beat. Each output has its own valid/ready handshake, so a stalled
//   consumer only blocks beats addressed to it. Select value 3 is illegal: such
//   beats are always accepted and discarded.
//
// Optional feature (compile-time macro DEMUX_DROP_CNT_EN):
//   When defined, an 8-bit saturating counter of discarded select-3 beats is
//   exposed on drop_cnt. When undefined, the port and counter are absent and
//   select-3 beats are still silently consumed.
//
// Ports:
//   clk                      rising-edge clock
//   rst_n                    asynchronous active-low reset
//   in_data   [WIDTH-1:0]    input beat payload
//   in_sel    [1:0]          destination (0/1/2 -> out0/out1/out2, 3 -> drop)
//   in_valid                 producer has a beat
//   in_ready                 beat is accepted this cycle (combinational)
//   outN_data [WIDTH-1:0]    payload held in port N (N = 0..2)
//   outN_valid               port N register holds a beat
//   outN_ready               consumer N takes the beat
//   drop_cnt  [7:0]          illegal-select drop count (DEMUX_DROP_CNT_EN only)
// -----------------------------------------------------------------------------
module demux_1x3 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data,
  output logic             out0_valid,
  output logic             out1_valid,
  output logic             out2_valid,
  input  logic             out0_ready,
  input  logic             out1_ready,
  input  logic             out2_ready
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  localparam int NUM_PORTS = 3;

  // Per-port storage, packed so each port is indexed by the generate loop.
  logic [NUM_PORTS-1:0]            valid_reg;
  logic [NUM_PORTS-1:0][WIDTH-1:0] data_reg;

  // Consumer readies gathered into a vector in port order.
  logic [NUM_PORTS-1:0] ready_vec;

  // One-hot push strobe per port for the beat accepted this cycle.
  logic [NUM_PORTS-1:0] push_vec;

  logic accept;
  logic drop_accept;

  assign ready_vec = {out2_ready, out1_ready, out0_ready};

  // ---------------------------------------------------------------------------
  // Input handshake
  // ---------------------------------------------------------------------------
  // A port can take a new beat when it is empty or is being popped in this same
  // cycle. Only the addressed port matters; illegal selects are always taken.
  // in_valid is deliberately not an input here.
  always_comb begin
    in_ready = 1'b1;
    case (in_sel)
      2'd0:    in_ready = !valid_reg[0] || ready_vec[0];
      2'd1:    in_ready = !valid_reg[1] || ready_vec[1];
      2'd2:    in_ready = !valid_reg[2] || ready_vec[2];
      default: in_ready = 1'b1;
    endcase
  end

  assign accept      = in_valid && in_ready;
  assign drop_accept = accept && (in_sel == 2'd3);

  // ---------------------------------------------------------------------------
  // Output port registers
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic pop;

      assign push_vec[gi] = accept && (in_sel == 2'(gi));
      assign pop          = valid_reg[gi] && ready_vec[gi];

      // A push wins over a pop in the same cycle: valid stays high and the
      // register takes the new beat, giving one beat per cycle per port.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg[gi] <= 1'b0;
          data_reg[gi]  <= '0;
        end else if (push_vec[gi]) begin
          valid_reg[gi] <= 1'b1;
          data_reg[gi]  <= in_data;
        end else if (pop) begin
          valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign out0_valid = valid_reg[0];
  assign out1_valid = valid_reg[1];
  assign out2_valid = valid_reg[2];

  assign out0_data  = data_reg[0];
  assign out1_data  = data_reg[1];
  assign out2_data  = data_reg[2];

  // ---------------------------------------------------------------------------
  // Illegal-select drop counter
  // ---------------------------------------------------------------------------
`ifdef DEMUX_DROP_CNT_EN
  logic [7:0] drop_cnt_reg;
  logic [7:0] drop_cnt_next;

  // Saturates at all-ones so a burst of bad selects never reads as "few".
  always_comb begin
    drop_cnt_next = drop_cnt_reg;
    if (drop_accept && (drop_cnt_reg != 8'hFF)) begin
      drop_cnt_next = drop_cnt_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_reg <= 8'd0;
    end else begin
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  assign drop_cnt = drop_cnt_reg;
`else
  // Illegal beats are consumed through in_ready with no further bookkeeping.
  logic drop_unused;
  assign drop_unused = drop_accept;
`endif

endmodule

// File: tb/tb_demux_1x3.sv
// -----------------------------------------------------------------------------
// tb_demux_1x3 -- directed self-checking bench for demux_1x3 (WIDTH = 1)
//
// Inputs are driven just after the falling edge and outputs sampled at the
// falling edge, so every rising edge sees stable stimulus. The drop counter
// checks are included only when DEMUX_DROP_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_demux_1x3;

  logic       clk;
  logic       rst_n;
  logic [0:0] in_data;
  logic [1:0] in_sel;
  logic       in_valid;
  logic       in_ready;
  logic [0:0] out0_data;
  logic [0:0] out1_data;
  logic [0:0] out2_data;
  logic       out0_valid;
  logic       out1_valid;
  logic       out2_valid;
  logic       out0_ready;
  logic       out1_ready;
  logic       out2_ready;
`ifdef DEMUX_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int n_cmp;
  int n_err;

  demux_1x3 #(.WIDTH(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out1_data  (out1_data),
    .out2_data  (out2_data),
    .out0_valid (out0_valid),
    .out1_valid (out1_valid),
    .out2_valid (out2_valid),
    .out0_ready (out0_ready),
    .out1_ready (out1_ready),
    .out2_ready (out2_ready)
`ifdef DEMUX_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_valids(input string tag, input logic [2:0] exp);
    check(tag, {29'd0, out2_valid, out1_valid, out0_valid}, {29'd0, exp});
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    in_data    = '0;
    in_sel     = 2'd0;
    in_valid   = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    out2_ready = 1'b0;

    // ---------------- reset state ----------------
    @(negedge clk);
    @(negedge clk);
    check_valids("reset_valids", 3'b000);
    check("reset_data", {29'd0, out2_data, out1_data, out0_data}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef DEMUX_DROP_CNT_EN
    check("reset_drop_cnt", {24'd0, drop_cnt}, 32'd0);
`endif
    rst_n = 1'b1;

    // ---------------- steering ----------------
    out0_ready = 1'b1; out1_ready = 1'b1; out2_ready = 1'b1;
    in_valid = 1'b1; in_data = 1'b1; in_sel = 2'd0;
    check("steer_in_ready0", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check_valids("steer_v_after0", 3'b001);
    check("steer_d0", {31'd0, out0_data}, 32'd1);
    in_sel = 2'd1;
    @(negedge clk);
    check_valids("steer_v_after1", 3'b010);
    check("steer_d1", {31'd0, out1_data}, 32'd1);
    in_sel = 2'd2;
    @(negedge clk);
    check_valids("steer_v_after2", 3'b100);
    check("steer_d2", {31'd0, out2_data}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    check_valids("steer_idle", 3'b000);

    // ---------------- backpressure isolation ----------------
    out1_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 1'b0;
    check("bp_first_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check_valids("bp_first_held", 3'b010);
    check("bp_first_data", {31'd0, out1_data}, 32'd0);
    in_data = 1'b1;
    check("bp_second_stall", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check_valids("bp_still_held", 3'b010);
    check("bp_data_stable", {31'd0, out1_data}, 32'd0);
    check("bp_still_stall", {31'd0, in_ready}, 32'd0);
    in_sel = 2'd2;
    check("bp_sel2_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check_valids("bp_sel2_taken", 3'b110);
    check("bp_sel2_data", {31'd0, out2_data}, 32'd1);
    check("bp_out1_kept", {31'd0, out1_data}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    check_valids("bp_out2_popped", 3'b010);
    out1_ready = 1'b1;
    @(negedge clk);
    check_valids("bp_out1_popped", 3'b000);

    // ---------------- simultaneous push/pop ----------------
    out0_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'd0; in_data = 1'b0;
    @(negedge clk);
    check_valids("pp_full", 3'b001);
    check("pp_old_data", {31'd0, out0_data}, 32'd0);
    out0_ready = 1'b1; in_data = 1'b1;
    check("pp_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check_valids("pp_valid_kept", 3'b001);
    check("pp_new_data", {31'd0, out0_data}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    check_valids("pp_drained", 3'b000);

    // ---------------- illegal select ----------------
    in_valid = 1'b1; in_sel = 2'd3; in_data = 1'b1;
    for (int i = 0; i < 300; i++) begin
      check("ill_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef DEMUX_DROP_CNT_EN
      check("ill_drop_cnt", {24'd0, drop_cnt}, (i < 255) ? i : 32'd255);
`endif
      @(negedge clk);
      check_valids("ill_no_valid", 3'b000);
    end
`ifdef DEMUX_DROP_CNT_EN
    check("ill_drop_sat", {24'd0, drop_cnt}, 32'd255);
`endif
    in_valid = 1'b0;

    // ---------------- throughput ----------------
    out2_ready = 1'b1;
    in_valid = 1'b1; in_sel = 2'd2;
    for (int i = 0; i < 16; i++) begin
      in_data = i[0];
      check("tp_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      check_valids("tp_valid", 3'b100);
      check("tp_data", {31'd0, out2_data}, {31'd0, i[0]});
    end
    in_valid = 1'b0;
    @(negedge clk);
    check_valids("tp_end", 3'b000);

    // ---------------- reset mid-stream ----------------
    out0_ready = 1'b0; out1_ready = 1'b0; out2_ready = 1'b0;
    in_valid = 1'b1;
    in_sel = 2'd0; in_data = 1'b1;
    @(negedge clk);
    in_sel = 2'd1; in_data = 1'b0;
    @(negedge clk);
    in_sel = 2'd2; in_data = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_valids("mid_filled", 3'b111);
    check("mid_filled_data", {29'd0, out2_data, out1_data, out0_data}, 32'b101);
    #2;
    rst_n = 1'b0;
    #1;
    check_valids("mid_async_valids", 3'b000);
    check("mid_async_data", {29'd0, out2_data, out1_data, out0_data}, 32'd0);
`ifdef DEMUX_DROP_CNT_EN
    check("mid_async_drop", {24'd0, drop_cnt}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    out1_ready = 1'b1;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 1'b1;
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check_valids("post_rst_accept", 3'b010);
    in_valid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
